// File: rtl/pe_group.sv
// pe_group: 1-D convolution tile of O_PEGroupSize output PEs.
// Each tile runs BlockCount blocks. A block loads weights and input words
// through ready/valid streams, then accumulates for W_PEGroupSize cycles.
// Initial partial sums are loaded during block 0 only.
// After the last block the results drain on the output stream.
// Optional debug outputs are enabled by defining PE_GROUP_DEBUG_EN.
module pe_group #(
  parameter int DataWidth       = 32,
  parameter int W_PEGroupSize   = 4,
  parameter int O_PEGroupSize   = 4,
  parameter int I_PEGroupSize   = 7,
  parameter int W_PEAddrWidth   = 2,
  parameter int O_PEAddrWidth   = 2,
  parameter int I_PEAddrWidth   = 3,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 3
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       W_DataInValid,
  output logic                       W_DataInRdy,
  input  logic [DataWidth-1:0]       W_DataIn,
  input  logic                       I_DataInValid,
  output logic                       I_DataInRdy,
  input  logic [DataWidth-1:0]       I_DataIn,
  input  logic                       O_DataInValid,
  output logic                       O_DataInRdy,
  input  logic [DataWidth-1:0]       O_DataIn,
  output logic                       O_DataOutValid,
  input  logic                       O_DataOutRdy,
  output logic [DataWidth-1:0]       O_DataOut
`ifdef PE_GROUP_DEBUG_EN
  ,
  output logic [O_PEAddrWidth-1:0]   Test_O_In_PEAddr,
  output logic [O_PEAddrWidth-1:0]   Test_O_Out_PEAddr,
  output logic [I_PEAddrWidth-1:0]   Test_I_PEAddr,
  output logic [BlockCountWidth-1:0] Test_I_Block_Counter,
  output logic [1:0]                 Test_State
`endif
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [BlockCountWidth-1:0] block_cnt_q, block_cnt_d;
  logic [W_PEAddrWidth-1:0]   w_addr_q, w_addr_d;
  logic                       w_full_q, w_full_d;
  logic [I_PEAddrWidth-1:0]   i_addr_q, i_addr_d;
  logic                       i_full_q, i_full_d;
  logic [O_PEAddrWidth-1:0]   o_in_addr_q, o_in_addr_d;
  logic                       o_in_full_q, o_in_full_d;
  logic [O_PEAddrWidth-1:0]   o_out_addr_q, o_out_addr_d;
  logic [W_PEAddrWidth-1:0]   comp_cnt_q, comp_cnt_d;
  logic [DataWidth-1:0]       w_q   [W_PEGroupSize];
  logic [DataWidth-1:0]       w_d   [W_PEGroupSize];
  logic [DataWidth-1:0]       i_q   [I_PEGroupSize];
  logic [DataWidth-1:0]       i_d   [I_PEGroupSize];
  logic [DataWidth-1:0]       acc_q [O_PEGroupSize];
  logic [DataWidth-1:0]       acc_d [O_PEGroupSize];
  logic [DataWidth-1:0]       prod  [O_PEGroupSize];

  // Handshake outputs depend only on registered state, never on inputs.
  assign W_DataInRdy    = (state_q == LOAD) && !w_full_q;
  assign I_DataInRdy    = (state_q == LOAD) && !i_full_q;
  assign O_DataInRdy    = (state_q == LOAD) && (block_cnt_q == '0) && !o_in_full_q;
  assign O_DataOutValid = (state_q == DRAIN);
  assign O_DataOut      = (state_q == DRAIN) ? acc_q[o_out_addr_q] : '0;

`ifdef PE_GROUP_DEBUG_EN
  assign Test_O_In_PEAddr     = o_in_addr_q;
  assign Test_O_Out_PEAddr    = o_out_addr_q;
  assign Test_I_PEAddr        = i_addr_q;
  assign Test_I_Block_Counter = block_cnt_q;
  assign Test_State           = state_q;
`endif

  // Compute cycle t: PE k multiplies weight t by input word k+t.
  // Products are truncated to DataWidth.
  always_comb begin
    for (int k = 0; k < O_PEGroupSize; k++) begin
      prod[k] = w_q[comp_cnt_q] *
                i_q[I_PEAddrWidth'(k) + I_PEAddrWidth'(comp_cnt_q)];
    end
  end

  // Next-state logic for the LOAD / COMPUTE / DRAIN sequencing and the datapath.
  always_comb begin
    state_d      = state_q;
    block_cnt_d  = block_cnt_q;
    w_addr_d     = w_addr_q;
    w_full_d     = w_full_q;
    i_addr_d     = i_addr_q;
    i_full_d     = i_full_q;
    o_in_addr_d  = o_in_addr_q;
    o_in_full_d  = o_in_full_q;
    o_out_addr_d = o_out_addr_q;
    comp_cnt_d   = comp_cnt_q;
    for (int j = 0; j < W_PEGroupSize; j++) w_d[j] = w_q[j];
    for (int j = 0; j < I_PEGroupSize; j++) i_d[j] = i_q[j];
    for (int k = 0; k < O_PEGroupSize; k++) acc_d[k] = acc_q[k];

    case (state_q)
      LOAD: begin
        if (W_DataInValid && W_DataInRdy) begin
          w_d[w_addr_q] = W_DataIn;
          w_addr_d      = w_addr_q + W_PEAddrWidth'(1);
          if (w_addr_q == W_PEAddrWidth'(W_PEGroupSize - 1)) w_full_d = 1'b1;
        end
        if (I_DataInValid && I_DataInRdy) begin
          i_d[i_addr_q] = I_DataIn;
          i_addr_d      = i_addr_q + I_PEAddrWidth'(1);
          if (i_addr_q == I_PEAddrWidth'(I_PEGroupSize - 1)) i_full_d = 1'b1;
        end
        // Initial partial sums go straight into the accumulators.
        if (O_DataInValid && O_DataInRdy) begin
          acc_d[o_in_addr_q] = O_DataIn;
          o_in_addr_d        = o_in_addr_q + O_PEAddrWidth'(1);
          if (o_in_addr_q == O_PEAddrWidth'(O_PEGroupSize - 1)) o_in_full_d = 1'b1;
        end
        // The partial-sum flag stays set for the whole tile.
        // Later blocks therefore only wait on weights and inputs.
        if (w_full_q && i_full_q && o_in_full_q) begin
          state_d    = COMPUTE;
          comp_cnt_d = '0;
        end
      end

      COMPUTE: begin
        for (int k = 0; k < O_PEGroupSize; k++) acc_d[k] = acc_q[k] + prod[k];
        comp_cnt_d = comp_cnt_q + W_PEAddrWidth'(1);
        if (comp_cnt_q == W_PEAddrWidth'(W_PEGroupSize - 1)) begin
          if (block_cnt_q != BlockCountWidth'(BlockCount - 1)) begin
            block_cnt_d = block_cnt_q + BlockCountWidth'(1);
            w_addr_d    = '0;
            w_full_d    = 1'b0;
            i_addr_d    = '0;
            i_full_d    = 1'b0;
            state_d     = LOAD;
          end else begin
            o_out_addr_d = '0;
            state_d      = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (O_DataOutRdy) begin
          if (o_out_addr_q == O_PEAddrWidth'(O_PEGroupSize - 1)) begin
            state_d      = LOAD;
            block_cnt_d  = '0;
            w_addr_d     = '0;
            w_full_d     = 1'b0;
            i_addr_d     = '0;
            i_full_d     = 1'b0;
            o_in_addr_d  = '0;
            o_in_full_d  = 1'b0;
            o_out_addr_d = '0;
            comp_cnt_d   = '0;
            for (int k = 0; k < O_PEGroupSize; k++) acc_d[k] = '0;
          end else begin
            o_out_addr_d = o_out_addr_q + O_PEAddrWidth'(1);
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers.
  // Asynchronous reset discards any tile in progress.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q      <= LOAD;
      block_cnt_q  <= '0;
      w_addr_q     <= '0;
      w_full_q     <= 1'b0;
      i_addr_q     <= '0;
      i_full_q     <= 1'b0;
      o_in_addr_q  <= '0;
      o_in_full_q  <= 1'b0;
      o_out_addr_q <= '0;
      comp_cnt_q   <= '0;
      for (int j = 0; j < W_PEGroupSize; j++) w_q[j] <= '0;
      for (int j = 0; j < I_PEGroupSize; j++) i_q[j] <= '0;
      for (int k = 0; k < O_PEGroupSize; k++) acc_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      block_cnt_q  <= block_cnt_d;
      w_addr_q     <= w_addr_d;
      w_full_q     <= w_full_d;
      i_addr_q     <= i_addr_d;
      i_full_q     <= i_full_d;
      o_in_addr_q  <= o_in_addr_d;
      o_in_full_q  <= o_in_full_d;
      o_out_addr_q <= o_out_addr_d;
      comp_cnt_q   <= comp_cnt_d;
      for (int j = 0; j < W_PEGroupSize; j++) w_q[j] <= w_d[j];
      for (int j = 0; j < I_PEGroupSize; j++) i_q[j] <= i_d[j];
      for (int k = 0; k < O_PEGroupSize; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_pe_group.sv
// Testbench for pe_group.
// Tile vectors are applied from a table.
// Expected results go through a scoreboard queue.
// Hand-written sequences cover output stall, held partial-sum valid and
// reset during COMPUTE.
module tb_pe_group;

  localparam int DW  = 32;
  localparam int LIM = 500;

  logic          clk = 1'b0;
  logic          aclr;
  logic          W_DataInValid, W_DataInRdy;
  logic [DW-1:0] W_DataIn;
  logic          I_DataInValid, I_DataInRdy;
  logic [DW-1:0] I_DataIn;
  logic          O_DataInValid, O_DataInRdy;
  logic [DW-1:0] O_DataIn;
  logic          O_DataOutValid, O_DataOutRdy;
  logic [DW-1:0] O_DataOut;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  pe_group dut (
    .clk            (clk),
    .aclr           (aclr),
    .W_DataInValid  (W_DataInValid),
    .W_DataInRdy    (W_DataInRdy),
    .W_DataIn       (W_DataIn),
    .I_DataInValid  (I_DataInValid),
    .I_DataInRdy    (I_DataInRdy),
    .I_DataIn       (I_DataIn),
    .O_DataInValid  (O_DataInValid),
    .O_DataInRdy    (O_DataInRdy),
    .O_DataIn       (O_DataIn),
    .O_DataOutValid (O_DataOutValid),
    .O_DataOutRdy   (O_DataOutRdy),
    .O_DataOut      (O_DataOut)
  );

  typedef struct {
    logic [3:0][DW-1:0] w;
    logic [6:0][DW-1:0] i;
    logic [3:0][DW-1:0] o;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  vec_t          vecs[4];
  vec_t          cur;
  logic [DW-1:0] expQ[$];
  int            assertions = 0;
  int            failures   = 0;
  bit            tileDone;

  // One comparison: count it, and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // An expired wait bound counts as a failed comparison.
  task automatic failTimeout(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: no handshake within %0d cycles", name, LIM);
  endtask

  // Reference model: direct sum over blocks and taps, truncated to DW bits.
  function automatic logic [3:0][DW-1:0] modelTile(input vec_t v);
    logic [3:0][DW-1:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k] = v.o[k];
      for (int b = 0; b < 4; b++)
        for (int j = 0; j < 4; j++)
          r[k] = r[k] + v.w[j] * v.i[k+j];
    end
    return r;
  endfunction

  // Send the tile's weights for nBlocks blocks.
  task automatic feedW(input int nBlocks);
    for (int b = 0; b < nBlocks; b++) begin
      for (int j = 0; j < 4; j++) begin
        int n = 0;
        W_DataInValid = 1'b1;
        W_DataIn      = cur.w[j];
        while (!W_DataInRdy && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) begin failTimeout("wHandshake"); W_DataInValid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
      end
    end
    W_DataInValid = 1'b0;
  endtask

  // Send the tile's input words for nBlocks blocks.
  task automatic feedI(input int nBlocks);
    for (int b = 0; b < nBlocks; b++) begin
      for (int j = 0; j < 7; j++) begin
        int n = 0;
        I_DataInValid = 1'b1;
        I_DataIn      = cur.i[j];
        while (!I_DataInRdy && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) begin failTimeout("iHandshake"); I_DataInValid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
      end
    end
    I_DataInValid = 1'b0;
  endtask

  // Send the four partial sums.
  // With hold set, keep junk valid until the tile ends and watch that it is refused.
  task automatic feedO(input bit hold);
    int seen = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      O_DataInValid = 1'b1;
      O_DataIn      = cur.o[k];
      while (!O_DataInRdy && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) begin failTimeout("oHandshake"); O_DataInValid = 1'b0; return; end
      @(posedge clk);
      @(negedge clk);
    end
    if (hold) begin
      int n = 0;
      O_DataIn = 32'h0BAD_0BAD;
      while (n < 5000) begin
        if (tileDone) break;
        if (O_DataInRdy) seen++;
        @(negedge clk);
        n++;
      end
      checkOutput("oRdyAfterBlock0", 32'(seen), 32'd0);
    end
    O_DataInValid = 1'b0;
  endtask

  // Accept the four results and compare them against the scoreboard.
  // With stall set, hold ready low for 5 cycles on the first result.
  task automatic collect(input bit stall);
    int got = 0;
    int n   = 0;
    int st  = 0;
    while (got < 4 && n < LIM * 4) begin
      @(negedge clk);
      n++;
      if (stall && got == 0 && (st > 0 || O_DataOutValid) && st < 5) begin
        O_DataOutRdy = 1'b0;
        checkOutput("stallValid", 32'(O_DataOutValid), 32'd1);
        checkOutput("stallData", O_DataOut, (expQ.size() > 0) ? expQ[0] : 32'hx);
        checkOutput("stallWRdy", 32'(W_DataInRdy), 32'd0);
        checkOutput("stallIRdy", 32'(I_DataInRdy), 32'd0);
        checkOutput("stallORdy", 32'(O_DataInRdy), 32'd0);
        st++;
      end else begin
        O_DataOutRdy = 1'b1;
        if (O_DataOutValid) begin
          if (expQ.size() == 0) failTimeout("scoreboardUnderflow");
          else checkOutput($sformatf("out%0d", got), O_DataOut, expQ.pop_front());
          got++;
        end
      end
    end
    if (got < 4) failTimeout("outputHandshake");
    @(posedge clk);
    tileDone = 1'b1;
  endtask

  // Run one full tile: push expectations, then drive all streams concurrently.
  task automatic applyStimulus(input vec_t v, input bit holdO, input bit stall);
    cur      = v;
    tileDone = 1'b0;
    for (int k = 0; k < 4; k++) expQ.push_back(v.exp[k]);
    fork
      feedW(4);
      feedI(4);
      feedO(holdO);
      collect(stall);
    join
    @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    aclr          = 1'b0;
    W_DataInValid = 1'b0; W_DataIn = '0;
    I_DataInValid = 1'b0; I_DataIn = '0;
    O_DataInValid = 1'b0; O_DataIn = '0;
    O_DataOutRdy  = 1'b1;
    tileDone      = 1'b0;

    for (int j = 0; j < 4; j++) begin
      vecs[0].w[j] = 32'd5;          vecs[0].o[j] = 32'd1;  vecs[0].exp[j] = 32'd1601;
      vecs[1].w[j] = 32'(j + 1);     vecs[1].o[j] = 32'd0;
      vecs[2].w[j] = 32'h0001_0000;  vecs[2].o[j] = 32'd7;  vecs[2].exp[j] = 32'd7;
      vecs[3].w[j] = $urandom;       vecs[3].o[j] = $urandom;
    end
    for (int j = 0; j < 7; j++) begin
      vecs[0].i[j] = 32'd20;
      vecs[1].i[j] = 32'(j);
      vecs[2].i[j] = 32'h0001_0000;
      vecs[3].i[j] = $urandom;
    end
    vecs[1].exp[0] = 32'd80;
    vecs[1].exp[1] = 32'd120;
    vecs[1].exp[2] = 32'd160;
    vecs[1].exp[3] = 32'd200;
    vecs[3].exp    = modelTile(vecs[3]);

    repeat (2) @(negedge clk);
    checkOutput("resetValid", 32'(O_DataOutValid), 32'd0);
    checkOutput("resetData",  O_DataOut, 32'd0);
    checkOutput("resetWRdy",  32'(W_DataInRdy), 32'd1);
    checkOutput("resetIRdy",  32'(I_DataInRdy), 32'd1);
    checkOutput("resetORdy",  32'(O_DataInRdy), 32'd1);
    aclr = 1'b1;

    for (int t = 0; t < 4; t++) applyStimulus(vecs[t], 1'b0, 1'b0);

    $display("[TB] output stall in DRAIN");
    applyStimulus(vecs[1], 1'b0, 1'b1);

    $display("[TB] partial-sum valid held after block 0");
    applyStimulus(vecs[0], 1'b1, 1'b0);

    $display("[TB] reset during COMPUTE of block 2");
    cur = vecs[0];
    fork
      feedW(3);
      feedI(3);
      feedO(1'b0);
    join
    @(negedge clk);
    checkOutput("inComputeWRdy", 32'(W_DataInRdy), 32'd0);
    #1 aclr = 1'b0;
    #1;
    checkOutput("midResetValid", 32'(O_DataOutValid), 32'd0);
    checkOutput("midResetData",  O_DataOut, 32'd0);
    checkOutput("midResetWRdy",  32'(W_DataInRdy), 32'd1);
    checkOutput("midResetIRdy",  32'(I_DataInRdy), 32'd1);
    checkOutput("midResetORdy",  32'(O_DataInRdy), 32'd1);
    @(negedge clk);
    aclr = 1'b1;
    applyStimulus(vecs[0], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pe_group.md
PE_GROUP -- requirements
Module: pe_group

Interface
REQ-001 Parameters SHALL be: DataWidth, 32, word width; W_PEGroupSize, 4, weight taps; O_PEGroupSize, 4, output PEs; I_PEGroupSize, 7, input words per block (= O_PEGroupSize+W_PEGroupSize-1); W_PEAddrWidth, 2; O_PEAddrWidth, 2; I_PEAddrWidth, 3; BlockCount, 4, blocks accumulated per tile; BlockCountWidth, 3.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 aclr  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 W_DataInValid / W_DataInRdy / W_DataIn  in / out / in  1 / 1 / DataWidth  weight stream.
REQ-005 I_DataInValid / I_DataInRdy / I_DataIn  in / out / in  1 / 1 / DataWidth  input-activation stream.
REQ-006 O_DataInValid / O_DataInRdy / O_DataIn  in / out / in  1 / 1 / DataWidth  initial partial-sum stream.
REQ-007 O_DataOutValid / O_DataOutRdy / O_DataOut  out / in / out  1 / 1 / DataWidth  result stream.

Function
REQ-008 Every stream SHALL transfer one word on a rising edge where valid and rdy are both 1; words SHALL be indexed 0..N-1 in arrival order by per-stream address counters.
REQ-009 Block SHALL compute a 1-D convolution tile: Out[k] = Oin[k] + sum over b<BlockCount, j<W_PEGroupSize of W_b[j]*I_b[k+j], k<O_PEGroupSize.
REQ-010 Arithmetic SHALL be two's-complement integer, product and sum truncated to DataWidth bits (modulo 2^DataWidth), no saturation.
REQ-011 FSM states SHALL be LOAD, COMPUTE, DRAIN; reset state LOAD with block counter 0.
REQ-012 In LOAD: W_DataInRdy=1 while fewer than W_PEGroupSize weights received; I_DataInRdy=1 while fewer than I_PEGroupSize inputs received; O_DataInRdy=1 only in block 0 while fewer than O_PEGroupSize partial sums received; W, I, O loading SHALL proceed concurrently and independently.
REQ-013 LOAD SHALL go to COMPUTE on the edge after all required words of the block are held; all Rdy outputs SHALL be 0 outside LOAD.
REQ-014 COMPUTE SHALL last exactly W_PEGroupSize cycles; in cycle t every output PE k SHALL perform acc[k] += W[t]*I[k+t].
REQ-015 After COMPUTE, if block counter < BlockCount-1: increment counter, clear W/I address counters, return to LOAD; else go to DRAIN.
REQ-016 DRAIN SHALL present acc[0..O_PEGroupSize-1] in order with O_DataOutValid=1; O_DataOut and O_DataOutValid SHALL hold stable while O_DataOutRdy=0; after the last word is accepted go to LOAD with block counter 0 and all address counters 0.
REQ-017 Valid inputs asserted while the corresponding Rdy=0 SHALL be ignored without side effect.
REQ-018 All Rdy and O_DataOutValid SHALL be combinational functions of registered state only (no combinational path from any input to any output).

Reset
REQ-019 While aclr=0: state LOAD, all counters 0, weight/input/accumulator registers 0, O_DataOutValid=0, O_DataOut=0; reset SHALL take effect immediately, including mid-COMPUTE or mid-DRAIN, discarding the tile.
REQ-020 First transfer SHALL be possible on the first rising edge with aclr=1.

Configuration
REQ-021 Macro PE_GROUP_DEBUG_EN, when defined, SHALL add outputs Test_O_In_PEAddr (O_PEAddrWidth), Test_O_Out_PEAddr (O_PEAddrWidth), Test_I_PEAddr (I_PEAddrWidth), Test_I_Block_Counter (BlockCountWidth), Test_State (2) mirroring internal registers; when undefined these ports SHALL not exist and function SHALL be identical.

Verification
REQ-022 W all 5, I all 20, O all 1, streams continuously valid, O_DataOutRdy=1 -> four outputs each 1601; block consumes 4 O + 4x(4 W + 7 I) words.
REQ-023 W=1,2,3,4, I=0..6 every block, O all 0 -> outputs 80, 120, 160, 200 in order.
REQ-024 DRAIN with O_DataOutRdy=0 for 5 cycles -> O_DataOutValid=1 and O_DataOut=first result unchanged, W/I/O Rdy=0 throughout; output resumes on Rdy=1.
REQ-025 aclr pulsed low during COMPUTE of block 2 -> all outputs reset values immediately; subsequent full tile (REQ-022 data) yields 1601 each.
REQ-026 W=0x00010000, I=0x00010000, O=7 -> products wrap to 0, outputs all 7.
REQ-027 O_DataInValid held 1 after block 0 loads -> no further O words accepted until next tile; accumulators unaffected.
